// File: rtl/impulse_pkg.sv
// Shared types for the impulse burst executor: FSM states, impulse type
// codes and the packed command word delivered by the command-memory writer.
package impulse_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_BLANK1,
        S_PULSE,
        S_GAP,
        S_BLANK2,
        S_DONE
    } state_e;

    localparam logic [1:0] TYPE_FIXED = 2'd0;
    localparam logic [1:0] TYPE_CHIRP = 2'd1;
    localparam logic [1:0] TYPE_STEP  = 2'd2;
    localparam logic [1:0] TYPE_ALT   = 2'd3;

    localparam int REQ_LEN_MIN = 3;

    // 338-bit command word, same field order as the writer's memory word
    typedef struct packed {
        logic [47:0] freq;
        logic [47:0] freq_step;
        logic [31:0] freq_rate;
        logic [63:0] time_start;
        logic [15:0] n_impuls;
        logic [1:0]  type_impulse;
        logic [31:0] ti;
        logic [31:0] tp;
        logic [31:0] tblank1;
        logic [31:0] tblank2;
    } cmd_t;

    // Off-time between impulses; a period shorter than the width means none
    function automatic logic [31:0] gap_len(input logic [31:0] ti,
                                            input logic [31:0] tp);
        return (tp > ti) ? tp - ti : 32'd0;
    endfunction

endpackage

// File: rtl/seg_timer.sv
// Loadable 32-bit down-counter that saturates at zero.
// Ports: clk, rst (sync, active-high), load/load_val, zero (count == 0).
module seg_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic        zero
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != 32'd0) begin
            count_d = count_q - 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == 32'd0);

endmodule

// File: rtl/impulse_executor.sv
// Plays out one impulse burst per command: blank1, N impulses, blank2, then
// a REQ_COMM pulse. Ports: CLK/rst, TIME, DATA_WR + *_z command fields in;
// PULSE, BLANK, FREQ_OUT, FREQ_VALID, REQ_COMM, BUSY, CMD_LATE out.
module impulse_executor
    import impulse_pkg::*;
#(
    parameter int REQ_LEN = 4
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic [63:0] TIME,
    input  logic        DATA_WR,
    input  logic [47:0] FREQ_z,
    input  logic [47:0] FREQ_STEP_z,
    input  logic [31:0] FREQ_RATE_z,
    input  logic [63:0] TIME_START_z,
    input  logic [15:0] N_impuls_z,
    input  logic [1:0]  TYPE_impulse_z,
    input  logic [31:0] Interval_Ti_z,
    input  logic [31:0] Interval_Tp_z,
    input  logic [31:0] Tblank1_z,
    input  logic [31:0] Tblank2_z,
    output logic        PULSE,
    output logic        BLANK,
    output logic [47:0] FREQ_OUT,
    output logic        FREQ_VALID,
    output logic        REQ_COMM,
    output logic        BUSY,
    output logic        CMD_LATE
);

    // The writer's 3-flop edge detector needs at least REQ_LEN_MIN cycles
    localparam int REQ_CYC = (REQ_LEN < REQ_LEN_MIN) ? REQ_LEN_MIN : REQ_LEN;

    state_e      state_q, state_d;
    cmd_t        act_q, act_d;
    cmd_t        pend_q, pend_d;
    cmd_t        new_cmd;
    logic        pv_q, pv_d;
    logic        first_q, first_d;
    logic [15:0] k_q, k_d;
    logic [47:0] fbase_q, fbase_d;
    logic [47:0] freq_q, freq_d;
    logic        pulse_q, pulse_d;
    logic        blank_q, blank_d;
    logic        req_q, req_d;
    logic        busy_q, busy_d;
    logic        late_q, late_d;

    logic        seg_load, seg_zero;
    logic [31:0] seg_val;
    logic        rate_load, rate_zero;
    logic [31:0] rate_val;

    logic        wr_act;
    logic        want_b1, want_gap, want_train, want_b2, want_done;
    logic        enter_pulse;
    logic [31:0] gap;
    logic [16:0] k_inc;
    logic [16:0] n_ext;

    assign new_cmd = '{
        freq:         FREQ_z,
        freq_step:    FREQ_STEP_z,
        freq_rate:    FREQ_RATE_z,
        time_start:   TIME_START_z,
        n_impuls:     N_impuls_z,
        type_impulse: TYPE_impulse_z,
        ti:           Interval_Ti_z,
        tp:           Interval_Tp_z,
        tblank1:      Tblank1_z,
        tblank2:      Tblank2_z
    };

    assign gap   = gap_len(act_q.ti, act_q.tp);
    assign k_inc = {1'b0, k_q} + 17'd1;
    assign n_ext = {1'b0, act_q.n_impuls};

    seg_timer u_seg (
        .clk      (CLK),
        .rst      (rst),
        .load     (seg_load),
        .load_val (seg_val),
        .zero     (seg_zero)
    );

    seg_timer u_rate (
        .clk      (CLK),
        .rst      (rst),
        .load     (rate_load),
        .load_val (rate_val),
        .zero     (rate_zero)
    );

    always_comb begin
        state_d     = state_q;
        act_d       = act_q;
        pend_d      = pend_q;
        pv_d        = pv_q;
        first_d     = first_q;
        k_d         = k_q;
        fbase_d     = fbase_q;
        freq_d      = freq_q;
        late_d      = 1'b0;
        seg_load    = 1'b0;
        seg_val     = '0;
        rate_load   = 1'b0;
        rate_val    = '0;
        want_b1     = 1'b0;
        want_gap    = 1'b0;
        want_train  = 1'b0;
        want_b2     = 1'b0;
        want_done   = 1'b0;
        enter_pulse = 1'b0;

        // A write lands in act when nothing is running, including the
        // final DONE cycle; otherwise it is queued in pend.
        wr_act = DATA_WR && (state_q == S_IDLE || state_q == S_ARMED ||
                             (state_q == S_DONE && seg_zero));

        unique case (state_q)
            S_IDLE: begin
                if (pv_q && !wr_act) begin
                    act_d   = pend_q;
                    pv_d    = 1'b0;
                    first_d = 1'b1;
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                first_d = 1'b0;
                if (!wr_act && TIME >= act_q.time_start) begin
                    late_d  = first_q && (TIME > act_q.time_start);
                    want_b1 = 1'b1;
                    k_d     = '0;
                    fbase_d = act_q.freq;
                end
            end
            S_BLANK1: begin
                if (seg_zero) begin
                    if (act_q.n_impuls != 16'd0) want_train = 1'b1;
                    else                         want_b2    = 1'b1;
                end
            end
            S_PULSE: begin
                if (seg_zero) want_gap = 1'b1;
            end
            S_GAP: begin
                if (seg_zero) begin
                    k_d     = k_inc[15:0];
                    fbase_d = fbase_q + act_q.freq_step;
                    if (k_inc < n_ext) want_train = 1'b1;
                    else               want_b2    = 1'b1;
                end
            end
            S_BLANK2: begin
                if (seg_zero) want_done = 1'b1;
            end
            S_DONE: begin
                if (seg_zero) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Resolve the next segment, falling through zero-length ones in
        // the same cycle so none of them costs a clock.
        if (want_b1) begin
            if (act_q.tblank1 != 32'd0) begin
                state_d  = S_BLANK1;
                seg_load = 1'b1;
                seg_val  = act_q.tblank1 - 32'd1;
            end else if (act_q.n_impuls != 16'd0) begin
                want_train = 1'b1;
            end else begin
                want_b2 = 1'b1;
            end
        end

        if (want_gap) begin
            if (gap != 32'd0) begin
                state_d  = S_GAP;
                seg_load = 1'b1;
                seg_val  = gap - 32'd1;
            end else begin
                k_d     = k_inc[15:0];
                fbase_d = fbase_q + act_q.freq_step;
                if (k_inc < n_ext) want_train = 1'b1;
                else               want_b2    = 1'b1;
            end
        end

        if (want_train) begin
            if (act_q.ti != 32'd0) begin
                state_d     = S_PULSE;
                seg_load    = 1'b1;
                seg_val     = act_q.ti - 32'd1;
                enter_pulse = 1'b1;
            end else if (gap != 32'd0) begin
                state_d  = S_GAP;
                seg_load = 1'b1;
                seg_val  = gap - 32'd1;
            end else begin
                // Every impulse is empty: the whole train takes no time
                k_d     = act_q.n_impuls;
                want_b2 = 1'b1;
            end
        end

        if (want_b2) begin
            if (act_q.tblank2 != 32'd0) begin
                state_d  = S_BLANK2;
                seg_load = 1'b1;
                seg_val  = act_q.tblank2 - 32'd1;
            end else begin
                want_done = 1'b1;
            end
        end

        if (want_done) begin
            state_d  = S_DONE;
            seg_load = 1'b1;
            seg_val  = 32'(REQ_CYC - 1);
        end

        if (enter_pulse) begin
            unique case (act_q.type_impulse)
                TYPE_STEP:            freq_d = fbase_d;
                TYPE_CHIRP:           freq_d = act_q.freq;
                TYPE_FIXED, TYPE_ALT: freq_d = act_q.freq;
            endcase
            rate_load = 1'b1;
            rate_val  = act_q.freq_rate - 32'd1;
        end else if (state_q == S_PULSE && !seg_zero && rate_zero &&
                     act_q.type_impulse == TYPE_CHIRP &&
                     act_q.freq_rate != 32'd0) begin
            freq_d    = freq_q + act_q.freq_step;
            rate_load = 1'b1;
            rate_val  = act_q.freq_rate - 32'd1;
        end

        if (DATA_WR) begin
            if (wr_act) begin
                act_d   = new_cmd;
                first_d = 1'b1;
                state_d = S_ARMED;
            end else begin
                pend_d = new_cmd;
                pv_d   = 1'b1;
            end
        end

        pulse_d = (state_d == S_PULSE);
        blank_d = (state_d == S_BLANK1) || (state_d == S_BLANK2);
        req_d   = (state_d == S_DONE);
        busy_d  = !((state_d == S_IDLE) || (state_d == S_ARMED));
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= S_IDLE;
            act_q   <= '0;
            pend_q  <= '0;
            pv_q    <= 1'b0;
            first_q <= 1'b0;
            k_q     <= '0;
            fbase_q <= '0;
            freq_q  <= '0;
            pulse_q <= 1'b0;
            blank_q <= 1'b0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            late_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            pv_q    <= pv_d;
            first_q <= first_d;
            k_q     <= k_d;
            fbase_q <= fbase_d;
            freq_q  <= freq_d;
            pulse_q <= pulse_d;
            blank_q <= blank_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            late_q  <= late_d;
        end
    end

    assign PULSE      = pulse_q;
    assign FREQ_VALID = pulse_q;
    assign BLANK      = blank_q;
    assign FREQ_OUT   = freq_q;
    assign REQ_COMM   = req_q;
    assign BUSY       = busy_q;
    assign CMD_LATE   = late_q;

endmodule

// File: tb/tb_impulse_executor.sv
// Self-checking bench for impulse_executor: directed table, hand-written
// replace/queue/reset sequences and randomized bursts vs. a timeline model.
module tb_impulse_executor;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] TIME;
    logic        DATA_WR;
    logic [47:0] FREQ_z, FREQ_STEP_z;
    logic [31:0] FREQ_RATE_z;
    logic [63:0] TIME_START_z;
    logic [15:0] N_impuls_z;
    logic [1:0]  TYPE_impulse_z;
    logic [31:0] Interval_Ti_z, Interval_Tp_z, Tblank1_z, Tblank2_z;
    logic        PULSE, BLANK, FREQ_VALID, REQ_COMM, BUSY, CMD_LATE;
    logic [47:0] FREQ_OUT;

    always #5 clk = ~clk;

    impulse_executor #(.REQ_LEN(4)) dut (
        .CLK(clk), .rst(rst), .TIME(TIME), .DATA_WR(DATA_WR),
        .FREQ_z(FREQ_z), .FREQ_STEP_z(FREQ_STEP_z),
        .FREQ_RATE_z(FREQ_RATE_z), .TIME_START_z(TIME_START_z),
        .N_impuls_z(N_impuls_z), .TYPE_impulse_z(TYPE_impulse_z),
        .Interval_Ti_z(Interval_Ti_z), .Interval_Tp_z(Interval_Tp_z),
        .Tblank1_z(Tblank1_z), .Tblank2_z(Tblank2_z),
        .PULSE(PULSE), .BLANK(BLANK), .FREQ_OUT(FREQ_OUT),
        .FREQ_VALID(FREQ_VALID), .REQ_COMM(REQ_COMM), .BUSY(BUSY),
        .CMD_LATE(CMD_LATE)
    );

    typedef struct {
        logic [47:0] f;
        logic [47:0] st;
        int          rate;
        longint      ts;
        int          n, ty, ti, tp, b1, b2;
    } tcmd_t;

    typedef struct {
        logic        pulse, blank, req, busy, late;
        logic [47:0] freq;
    } tout_t;

    typedef struct {
        tcmd_t c;
        int    issue, first, req, np, late;
    } vec_t;

    tout_t exp_map[int];
    int    cyc, n_cmp, n_bad;
    int    first_act, first_req, pcount, saw_late;

    function automatic tcmd_t mk(longint ts, int b1, int n, int ti, int tp,
                                 int b2, int ty, logic [47:0] f,
                                 logic [47:0] st, int rate);
        tcmd_t c;
        c.ts = ts; c.b1 = b1; c.n = n; c.ti = ti; c.tp = tp; c.b2 = b2;
        c.ty = ty; c.f = f; c.st = st; c.rate = rate;
        return c;
    endfunction

    // Frequency of cycle j inside impulse k, straight from the type rules
    function automatic logic [47:0] pfreq(tcmd_t c, int k, int j);
        logic [47:0] r;
        r = c.f;
        if (c.ty == 1 && c.rate != 0) r = c.f + 48'(j / c.rate) * c.st;
        if (c.ty == 2) r = c.f + 48'(k) * c.st;
        return r;
    endfunction

    function automatic void put(int p, logic pu, logic bl, logic rq,
                                logic [47:0] f);
        tout_t o;
        o.pulse = pu; o.blank = bl; o.req = rq; o.busy = 1'b1;
        o.late = 1'b0; o.freq = f;
        exp_map[p] = o;
    endfunction

    // Command armed the cycle after 'issue'; expected outputs from t+1 on
    task automatic schedule(input tcmd_t c, input int issue,
                            output int t, output int e);
        int p, g;
        logic late;
        tout_t o;
        late = c.ts < longint'(issue + 1);
        t = late ? issue + 1 : int'(c.ts);
        if (t < issue + 1) t = issue + 1;
        g = (c.tp > c.ti) ? c.tp - c.ti : 0;
        p = t + 1;
        repeat (c.b1) begin put(p, 0, 1, 0, 0); p++; end
        for (int k = 0; k < c.n; k++) begin
            for (int j = 0; j < c.ti; j++) begin
                put(p, 1, 0, 0, pfreq(c, k, j)); p++;
            end
            repeat (g) begin put(p, 0, 0, 0, 0); p++; end
        end
        repeat (c.b2) begin put(p, 0, 1, 0, 0); p++; end
        repeat (4) begin put(p, 0, 0, 1, 0); p++; end
        o = exp_map[t + 1];
        o.late = late;
        exp_map[t + 1] = o;
        e = p - 1;
    endtask

    task automatic check_out();
        tout_t e;
        logic bad;
        e = '{pulse: 0, blank: 0, req: 0, busy: 0, late: 0, freq: 0};
        if (exp_map.exists(cyc)) e = exp_map[cyc];
        n_cmp++;
        bad = (PULSE !== e.pulse) || (BLANK !== e.blank) ||
              (REQ_COMM !== e.req) || (BUSY !== e.busy) ||
              (CMD_LATE !== e.late) || (FREQ_VALID !== e.pulse) ||
              (e.pulse && FREQ_OUT !== e.freq);
        if (bad) begin
            n_bad++;
            $display("FAIL cycle%0d outputs: got p%b b%b r%b busy%b late%b fv%b f=%h, want p%b b%b r%b busy%b late%b f=%h",
                     cyc, PULSE, BLANK, REQ_COMM, BUSY, CMD_LATE, FREQ_VALID,
                     FREQ_OUT, e.pulse, e.blank, e.req, e.busy, e.late, e.freq);
        end
        if ((PULSE || BLANK) && first_act < 0) first_act = cyc;
        if (REQ_COMM && first_req < 0) first_req = cyc;
        if (PULSE) pcount++;
        if (CMD_LATE) saw_late = 1;
    endtask

    task automatic chk_int(string name, int got, int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic clr_trk();
        first_act = -1; first_req = -1; pcount = 0; saw_late = 0;
    endtask

    // One label per cycle: TIME = cyc while the DUT samples at the next
    // posedge; outputs seen here were registered at the previous one.
    task automatic step();
        @(negedge clk);
        cyc++;
        TIME = 64'(cyc);
        DATA_WR = 1'b0;
        check_out();
    endtask

    task automatic run_to(int target);
        while (cyc < target) step();
    endtask

    task automatic apply_cmd(tcmd_t c);
        FREQ_z = c.f; FREQ_STEP_z = c.st; FREQ_RATE_z = 32'(c.rate);
        TIME_START_z = 64'(c.ts); N_impuls_z = 16'(c.n);
        TYPE_impulse_z = 2'(c.ty); Interval_Ti_z = 32'(c.ti);
        Interval_Tp_z = 32'(c.tp); Tblank1_z = 32'(c.b1);
        Tblank2_z = 32'(c.b2);
        DATA_WR = 1'b1;
    endtask

    function automatic tcmd_t rnd_cmd(longint ts);
        tcmd_t c;
        c = mk(ts, $urandom_range(0, 4), $urandom_range(0, 4),
               $urandom_range(0, 5), $urandom_range(0, 8),
               $urandom_range(0, 4), $urandom_range(0, 3),
               {$urandom, $urandom}, {$urandom, $urandom},
               $urandom_range(0, 4));
        return c;
    endfunction

    vec_t vt[6];

    initial begin
        int t, e, e2, q, eff;
        tcmd_t c;
        int keys[$];

        cyc = 0; n_cmp = 0; n_bad = 0;
        clr_trk();
        rst = 1'b1; TIME = '0; DATA_WR = 1'b0;
        apply_cmd(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        DATA_WR = 1'b0;

        repeat (3) step();
        rst = 1'b0;
        chk_int("reset FREQ_OUT", int'(FREQ_OUT), 0);

        vt[0] = '{mk(1000, 5, 3, 10, 25, 7, 0, 48'h1000, 0, 0),
                  990, 1001, 1088, 30, 0};
        vt[1] = '{mk(1110, 2, 4, 3, 5, 1, 2, 48'd100, 48'hFFFF_FFFF_FFFF, 0),
                  1100, 1111, 1134, 12, 0};
        vt[2] = '{mk(1210, 0, 2, 8, 10, 0, 1, 48'hFFFF_FFFF_FFFF, 48'd2, 3),
                  1200, 1211, 1231, 16, 0};
        vt[3] = '{mk(1310, 0, 0, 4, 9, 0, 0, 48'd7, 0, 0),
                  1300, -1, 1311, 0, 0};
        vt[4] = '{mk(1350, 1, 1, 2, 2, 1, 0, 48'd9, 0, 0),
                  1400, 1402, 1406, 2, 1};
        vt[5] = '{mk(1455, 1, 2, 0, 3, 0, 0, 48'd9, 0, 0),
                  1450, 1456, 1463, 0, 0};

        foreach (vt[i]) begin
            run_to(vt[i].issue);
            clr_trk();
            apply_cmd(vt[i].c);
            schedule(vt[i].c, vt[i].issue, t, e);
            run_to(e + 2);
            chk_int($sformatf("vec%0d first active", i), first_act, vt[i].first);
            chk_int($sformatf("vec%0d REQ rise", i), first_req, vt[i].req);
            chk_int($sformatf("vec%0d pulse cycles", i), pcount, vt[i].np);
            chk_int($sformatf("vec%0d late", i), saw_late, vt[i].late);
        end

        // Replace while armed, then queue during the burst
        run_to(1480);
        apply_cmd(mk(2000, 2, 1, 3, 3, 2, 0, 48'd1, 0, 0));
        run_to(1490);
        clr_trk();
        c = mk(1500, 2, 1, 3, 3, 2, 0, 48'd2, 0, 0);
        apply_cmd(c);
        schedule(c, 1490, t, e);
        run_to(1503);
        c = mk(1600, 1, 2, 2, 4, 1, 2, 48'd5, 48'd3, 0);
        apply_cmd(c);
        chk_int("replace first active", first_act, 1501);
        schedule(c, e + 1, t, e2);
        run_to(e + 1);
        clr_trk();
        run_to(e2);
        chk_int("queued first active", first_act, 1601);
        chk_int("queued REQ rise", first_req, 1611);
        // New command in the final DONE cycle goes straight to act
        clr_trk();
        c = mk(1620, 0, 1, 1, 1, 0, 0, 48'd3, 0, 0);
        apply_cmd(c);
        schedule(c, e2, t, e);
        run_to(e + 2);
        chk_int("done-edge write first active", first_act, 1621);

        // Reset in mid-pulse with a command queued: nothing may follow
        run_to(1700);
        c = mk(1705, 1, 2, 5, 8, 1, 0, 48'h123, 0, 0);
        apply_cmd(c);
        schedule(c, 1700, t, e);
        run_to(1708);
        apply_cmd(mk(1750, 1, 1, 1, 1, 0, 0, 48'd4, 0, 0));
        step();
        chk_int("pulse before reset", int'(PULSE), 1);
        rst = 1'b1;
        foreach (exp_map[k]) if (k >= 1710) keys.push_back(k);
        foreach (keys[i]) exp_map.delete(keys[i]);
        step();
        rst = 1'b0;
        chk_int("reset mid-burst FREQ_OUT", int'(FREQ_OUT), 0);
        run_to(1800);

        // Randomized bursts, some with a second command written mid-burst
        for (int it = 0; it < 40; it++) begin
            c = rnd_cmd(longint'(cyc) + longint'(int'($urandom_range(0, 8)) - 3));
            apply_cmd(c);
            schedule(c, cyc, t, e);
            if ($urandom_range(0, 1) == 1) begin
                q = int'($urandom_range(t + 1, e));
                run_to(q);
                c = rnd_cmd(longint'(e) + longint'(int'($urandom_range(0, 8)) - 3));
                apply_cmd(c);
                eff = (q == e) ? e : e + 1;
                schedule(c, eff, t, e);
            end
            run_to(e + int'($urandom_range(2, 4)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
